// File: rtl/median_sort_ctrl_pkg.sv
// Shared definitions for the 9-sample median sorter.
// Holds the window geometry, sort schedule sizes, the controller state
// encoding and the pair-index lookup used by the sort sequencer.
package median_sort_ctrl_pkg;

  localparam int DATA_W_DEF      = 10;
  localparam int WIN             = 9;
  localparam int MED_IDX         = 4;
  localparam int NUM_PHASES      = 9;
  localparam int PAIRS_PER_PHASE = 4;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Lower index of the compare pair.
  // Even phases use pairs (0,1),(2,3),(4,5),(6,7).
  // Odd phases use pairs (1,2),(3,4),(5,6),(7,8).
  // The upper index is always lo+1, so lo = 2*pair + odd.
  function automatic logic [3:0] pair_lo_idx(input logic odd_phase, input logic [1:0] pair);
    return {1'b0, pair, odd_phase};
  endfunction

endpackage

// File: rtl/median_sort_ctrl_cmp_unit.sv
// cmp_unit: registered compare-exchange element.
//   clk, rst : clock and synchronous active-high reset (clears both outputs)
//   in1, in2 : operands
//   out1     : min(in1, in2), one cycle later
//   out2     : max(in1, in2), one cycle later
module cmp_unit
  import median_sort_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2
);

  logic [DATA_W-1:0] out1_q, out1_d;
  logic [DATA_W-1:0] out2_q, out2_d;

  // When the operands are equal, taking the no-swap branch is harmless
  // because both outputs carry the same value.
  always_comb begin
    out1_d = in1;
    out2_d = in2;
    if (in2 < in1) begin
      out1_d = in2;
      out2_d = in1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out1_q <= '0;
      out2_q <= '0;
    end else begin
      out1_q <= out1_d;
      out2_q <= out2_d;
    end
  end

  assign out1 = out1_q;
  assign out2 = out2_q;

endmodule

// File: rtl/median_sort_ctrl.sv
// median_sort_ctrl: loads a 9-sample window, sorts it in place with a single
// time-shared compare-exchange unit using odd-even transposition, and
// presents the median.
//   clk, rst            : clock and synchronous active-high reset
//   in_data/in_valid    : sample input; transfers when in_valid && in_ready
//   in_ready            : high only while loading the window
//   out_data/out_valid  : median output; held until out_valid && out_ready
//   out_ready           : consumer handshake
//   busy                : high while sorting or draining the last compare
module median_sort_ctrl
  import median_sort_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  phase_q, phase_d;
  logic [1:0]  pair_q, pair_d;

  // Write-back pipeline: carries the pair indices alongside the compare
  // unit so the result lands two edges after the issue.
  logic        wb_valid_q, wb_valid_d;
  logic [3:0]  wb_lo_q, wb_lo_d;
  logic [3:0]  wb_hi_q, wb_hi_d;

  logic                          issue;
  logic                          load_we;
  logic [3:0]                    lo_idx;
  logic [3:0]                    hi_idx;
  logic [WIN-1:0][DATA_W-1:0]    w_all;
  logic [DATA_W-1:0]             cmp_in1;
  logic [DATA_W-1:0]             cmp_in2;
  logic [DATA_W-1:0]             cmp_out1;
  logic [DATA_W-1:0]             cmp_out2;

  assign issue   = (state_q == ST_SORT);
  assign load_we = (state_q == ST_LOAD) && in_valid;
  assign lo_idx  = pair_lo_idx(phase_q[0], pair_q);
  assign hi_idx  = lo_idx + 4'd1;
  assign cmp_in1 = w_all[lo_idx];
  assign cmp_in2 = w_all[hi_idx];

  // The issue order means a pair never reads a register whose write-back
  // is still pending. A result issued in cycle k is written at edge k+2.
  // By then the next pair has already been read, and that next pair
  // never overlaps the previous one, so no forwarding path is required.
  cmp_unit #(
    .DATA_W(DATA_W)
  ) u_cmp (
    .clk (clk),
    .rst (rst),
    .in1 (cmp_in1),
    .in2 (cmp_in2),
    .out1(cmp_out1),
    .out2(cmp_out2)
  );

  // Window registers. Loading and write-back never coincide, because
  // write-backs only occur during SORT and DRAIN.
  for (genvar gi = 0; gi < WIN; gi++) begin : g_win
    localparam logic [3:0] IDX = 4'(gi);
    logic [DATA_W-1:0] w_q, w_d;

    always_comb begin
      w_d = w_q;
      if (load_we && (cnt_q == IDX)) begin
        w_d = in_data;
      end else if (wb_valid_q && (wb_lo_q == IDX)) begin
        w_d = cmp_out1;
      end else if (wb_valid_q && (wb_hi_q == IDX)) begin
        w_d = cmp_out2;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        w_q <= '0;
      end else begin
        w_q <= w_d;
      end
    end

    assign w_all[gi] = w_q;
  end

  always_comb begin
    wb_valid_d = issue;
    wb_lo_d    = lo_idx;
    wb_hi_d    = hi_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      phase_q    <= '0;
      pair_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_lo_q    <= '0;
      wb_hi_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      pair_q     <= pair_d;
      wb_valid_q <= wb_valid_d;
      wb_lo_q    <= wb_lo_d;
      wb_hi_q    <= wb_hi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    pair_d    = pair_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;

    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt_q == 4'(WIN - 1)) begin
            cnt_d   = '0;
            state_d = ST_SORT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      ST_SORT: begin
        busy = 1'b1;
        if (pair_q == 2'(PAIRS_PER_PHASE - 1)) begin
          pair_d = '0;
          if (phase_q == 4'(NUM_PHASES - 1)) begin
            phase_d = '0;
            state_d = ST_DRAIN;
          end else begin
            phase_d = phase_q + 4'd1;
          end
        end else begin
          pair_d = pair_q + 2'd1;
        end
      end

      // One extra cycle lets the final issued pair be written back.
      ST_DRAIN: begin
        busy    = 1'b1;
        state_d = ST_OUT;
      end

      ST_OUT: begin
        out_valid = 1'b1;
        out_data  = w_all[MED_IDX];
        if (out_ready) begin
          state_d = ST_LOAD;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_median_sort_ctrl.sv
module tb_median_sort_ctrl;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int accept_cyc = 0;

  median_sort_ctrl #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] s[9];
    int            med;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the median is the middle element of the sorted window.
  function automatic int median9(input logic [DW-1:0] s[9]);
    int q[$];
    for (int i = 0; i < 9; i++) q.push_back(int'(s[i]));
    q.sort();
    return q[4];
  endfunction

  // Sends 9 samples, inserting up to gap_max idle cycles between them.
  // With junk set, a random sample is offered while the block is busy.
  task automatic send_window(input logic [DW-1:0] s[9], input int gap_max, input bit junk);
    int waited;
    for (int i = 0; i < 9; i++) begin
      in_data  = s[i];
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 100) begin
        tick();
        waited++;
      end
      if (!in_ready) begin
        n_vec++;
        n_err++;
        $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      tick();
      if (i == 8) accept_cyc = cyc;
      if (i < 8 && gap_max > 0) begin
        int g;
        g = $urandom_range(0, gap_max);
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          in_data  = DW'($urandom);
          tick();
        end
      end
    end
    check("busy_in_sort", int'(busy), 1);
    check("in_ready_in_sort", int'(in_ready), 0);
    in_valid = junk;
    in_data  = DW'($urandom);
  endtask

  // Waits for the result, checks latency and value, then completes the
  // handshake (optionally with random backpressure).
  task automatic wait_result(input int exp, input string nm, input bit rand_bp);
    int waited;
    waited = 0;
    while (!out_valid && waited < 100) begin
      tick();
      waited++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: out_valid got 0 expected 1", nm);
      return;
    end
    check({nm, "_latency"}, cyc - accept_cyc, 37);
    check(nm, int'(out_data), exp);
    waited = 0;
    while (waited < 50) begin
      logic hs;
      out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = out_ready;
      tick();
      waited++;
      if (hs) break;
      check({nm, "_hold_valid"}, int'(out_valid), 1);
      check({nm, "_hold_data"}, int'(out_data), exp);
    end
    out_ready = 1'b1;
    check({nm, "_pulse_end"}, int'(out_valid), 0);
    check({nm, "_back_to_load"}, int'(in_ready), 1);
  endtask

  initial begin
    logic [DW-1:0] w[9];
    int            exp;

    tbl[0].s = '{10'd9, 10'd8, 10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1};
    tbl[0].med = 5;
    tbl[1].s = '{10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1023,
                 10'd1023, 10'd1023, 10'd1023, 10'd1023};
    tbl[1].med = 1023;
    tbl[2].s = '{10'd0, 10'd1023, 10'd0, 10'd1023, 10'd0,
                 10'd1023, 10'd0, 10'd1023, 10'd0};
    tbl[2].med = 0;
    tbl[3].s = '{10'd3, 10'd3, 10'd7, 10'd1, 10'd3, 10'd9, 10'd3, 10'd0, 10'd3};
    tbl[3].med = 3;

    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // Directed table, back-to-back loads.
    for (int t = 0; t < 4; t++) begin
      send_window(tbl[t].s, 0, 1'b0);
      wait_result(tbl[t].med, $sformatf("tbl%0d", t), 1'b0);
    end

    // Backpressure for 10 cycles in OUT.
    w = '{10'd50, 10'd40, 10'd30, 10'd20, 10'd10, 10'd90, 10'd80, 10'd70, 10'd60};
    send_window(w, 0, 1'b1);
    out_ready = 1'b0;
    begin
      int waited;
      waited = 0;
      while (!out_valid && waited < 100) begin
        tick();
        waited++;
      end
    end
    in_valid = 1'b0;
    check("bp_latency", cyc - accept_cyc, 37);
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", int'(out_valid), 1);
      check("bp_data", int'(out_data), 50);
      check("bp_in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_in_ready", int'(in_ready), 1);

    // in_valid toggling 1,0,1,0 during load.
    w = '{10'd100, 10'd7, 10'd512, 10'd33, 10'd900, 10'd1, 10'd250, 10'd250, 10'd64};
    send_window(w, 1, 1'b0);
    wait_result(median9(w), "toggle", 1'b0);

    // Reset during SORT cycle 20.
    w = '{10'd5, 10'd900, 10'd800, 10'd700, 10'd600, 10'd500, 10'd400, 10'd300, 10'd200};
    send_window(w, 0, 1'b0);
    for (int k = 0; k < 20; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midsort_rst_in_ready", int'(in_ready), 1);
    check("midsort_rst_out_valid", int'(out_valid), 0);
    check("midsort_rst_out_data", int'(out_data), 0);
    check("midsort_rst_busy", int'(busy), 0);
    w = '{10'd10, 10'd20, 10'd30, 10'd40, 10'd50, 10'd60, 10'd70, 10'd80, 10'd90};
    send_window(w, 0, 1'b0);
    wait_result(50, "after_rst", 1'b0);

    // Randomized windows against the reference model.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 9; i++) begin
        w[i] = (r % 2 == 0) ? DW'($urandom_range(0, 1023)) : DW'($urandom_range(0, 3));
      end
      exp = median9(w);
      send_window(w, 2, 1'b1);
      wait_result(exp, $sformatf("rand%0d", r), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
